decode_stage: RTL



---
 rtl/decode_stage.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: field extraction, immediate generation, instruction
// classification and illegal-encoding detection, registered behind a
// valid/ready handshake with an optional two-entry skid buffer.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_type_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic            rd_we;
    logic            illegal;
  } dec_t;

  dec_t dec;
  dec_t out_q;
  logic out_v;
  logic in_fire;
  logic out_fire;
  logic sign;
  logic bad;
  logic writes;

  // Combinational decode of the incoming instruction word.
  always_comb begin
    dec          = '0;
    dec.pc       = pc_i;
    dec.opcode   = instr_i[6:0];
    dec.rd       = instr_i[11:7];
    dec.rs1      = instr_i[19:15];
    dec.rs2      = instr_i[24:20];
    dec.funct3   = instr_i[14:12];
    dec.funct7   = instr_i[31:25];
    sign         = instr_i[31];
    bad          = 1'b0;
    writes       = 1'b0;

    case (dec.opcode)
      OPC_STORE:           dec.imm_type = IMM_S;
      OPC_BRANCH:          dec.imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:  dec.imm_type = IMM_U;
      OPC_JAL:             dec.imm_type = IMM_J;
      default:             dec.imm_type = IMM_I;
    endcase

    case (dec.imm_type)
      IMM_S:   dec.imm = {{(XLEN-11){sign}}, instr_i[30:25], instr_i[11:7]};
      IMM_B:   dec.imm = {{(XLEN-12){sign}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   dec.imm = {{(XLEN-31){sign}}, instr_i[30:12], 12'b0};
      IMM_J:   dec.imm = {{(XLEN-20){sign}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: dec.imm = {{(XLEN-11){sign}}, instr_i[30:20]};
    endcase

    case (dec.opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes = 1'b1;
      OPC_MISC, OPC_SYSTEM:        writes = 1'b0;
      OPC_LOAD: begin
        writes = 1'b1;
        bad    = (dec.funct3 == 3'd3) || (dec.funct3 == 3'd6) || (dec.funct3 == 3'd7);
      end
      OPC_STORE:  bad = (dec.funct3 > 3'd2);
      OPC_BRANCH: bad = (dec.funct3 == 3'd2) || (dec.funct3 == 3'd3);
      OPC_JALR: begin
        writes = 1'b1;
        bad    = (dec.funct3 != 3'd0);
      end
      OPC_OP: begin
        writes = 1'b1;
        bad    = ((dec.funct7 != 7'h00) && (dec.funct7 != 7'h20)) ||
                 ((dec.funct7 == 7'h20) && (dec.funct3 != 3'd0) && (dec.funct3 != 3'd5));
      end
      OPC_OPIMM: begin
        writes = 1'b1;
        bad    = ((dec.funct3 == 3'd1) && (dec.funct7 != 7'h00)) ||
                 ((dec.funct3 == 3'd5) && (dec.funct7 != 7'h00) && (dec.funct7 != 7'h20));
      end
      default: bad = 1'b1;
    endcase

    dec.illegal = bad || (instr_i[1:0] != 2'b11);
    dec.rd_we   = writes && (dec.rd != 5'd0) && !dec.illegal;
  end

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_v && out_ready_i;

  generate
    if (SKID_EN) begin : g_skid
      dec_t skid_q;
      logic skid_v;

      // skid_v is a flop, so in_ready_o never depends on out_ready_i.
      assign in_ready_o = !skid_v;

      // Two-slot FIFO: OUT drives the outputs, SKID catches the beat accepted while OUT stalls.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          out_v  <= 1'b0;
          out_q  <= '0;
          skid_v <= 1'b0;
          skid_q <= '0;
        end else if (flush_i) begin
          out_v  <= 1'b0;
          skid_v <= 1'b0;
        end else if (out_fire || !out_v) begin
          if (skid_v) begin
            out_q  <= skid_q;
            skid_v <= in_fire;
            if (in_fire) skid_q <= dec;
          end else begin
            out_v <= in_fire;
            if (in_fire) out_q <= dec;
          end
        end else if (in_fire) begin
          skid_v <= 1'b1;
          skid_q <= dec;
        end
      end
    end else begin : g_single
      assign in_ready_o = !out_v || out_ready_i;

      // Single output register; refilled in the same cycle it drains.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          out_v <= 1'b0;
          out_q <= '0;
        end else if (flush_i) begin
          out_v <= 1'b0;
        end else if (in_fire) begin
          out_v <= 1'b1;
          out_q <= dec;
        end else if (out_fire) begin
          out_v <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_valid_o = out_v;
  assign pc_o        = out_q.pc;
  assign opcode_o    = out_q.opcode;
  assign rd_o        = out_q.rd;
  assign rs1_o       = out_q.rs1;
  assign rs2_o       = out_q.rs2;
  assign funct3_o    = out_q.funct3;
  assign funct7_o    = out_q.funct7;
  assign imm_o       = out_q.imm;
  assign imm_type_o  = out_q.imm_type;
  assign rd_we_o     = out_q.rd_we;
  assign illegal_o   = out_q.illegal;

endmodule
